// File: rtl/gcd_pkg.sv
// Shared width and state encoding for the subtractive GCD engine.
package gcd_pkg;

  localparam int GCD_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CMP  = 3'd2,
    S_SUBA = 3'd3,
    S_SUBB = 3'd4,
    S_DONE = 3'd5
  } state_e;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers RA/RB with load and larger-minus-smaller subtract,
// plus the comparison flags consumed by the control FSM.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         sub_a,
  input  logic         sub_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] ra,
  output logic [W-1:0] rb,
  output logic         eq,
  output logic         gt,
  output logic         ra_zero,
  output logic         rb_zero
);

  logic [W-1:0] ra_q, ra_d;
  logic [W-1:0] rb_q, rb_d;

  always_comb begin
    ra_d = ra_q;
    rb_d = rb_q;
    if (load) begin
      ra_d = a;
      rb_d = b;
    end else if (sub_a) begin
      ra_d = ra_q - rb_q;
    end else if (sub_b) begin
      rb_d = rb_q - ra_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      ra_q <= ra_d;
      rb_q <= rb_d;
    end
  end

  assign ra      = ra_q;
  assign rb      = rb_q;
  assign eq      = (ra_q == rb_q);
  assign gt      = (ra_q > rb_q);
  assign ra_zero = (ra_q == '0);
  assign rb_zero = (rb_q == '0);

endmodule

// File: rtl/gcd_control_path.sv
// Control FSM for the subtractive GCD engine: sequences load/compare/subtract,
// owns the gcd result register and the Moore done output.
module gcd_control_path
  import gcd_pkg::*;
#(
  parameter int W = GCD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         start,
  output logic [W-1:0] gcd,
  output logic         done,
  output logic [2:0]   dbg_state
);

  state_e       state, state_d;
  logic [W-1:0] gcd_q, gcd_d;
  logic         load, sub_a, sub_b;
  logic [W-1:0] ra, rb;
  logic         eq, gt, ra_zero, rb_zero;

  gcd_datapath #(.W(W)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .sub_a   (sub_a),
    .sub_b   (sub_b),
    .a       (a),
    .b       (b),
    .ra      (ra),
    .rb      (rb),
    .eq      (eq),
    .gt      (gt),
    .ra_zero (ra_zero),
    .rb_zero (rb_zero)
  );

  always_comb begin
    state_d = state;
    gcd_d   = gcd_q;
    load    = 1'b0;
    sub_a   = 1'b0;
    sub_b   = 1'b0;
    case (state)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_CMP;
      end
      // Zero operands terminate immediately so gcd(x,0)=gcd(0,x)=x.
      S_CMP: begin
        if (rb_zero || eq) begin
          gcd_d   = ra;
          state_d = S_DONE;
        end else if (ra_zero) begin
          gcd_d   = rb;
          state_d = S_DONE;
        end else if (gt) begin
          state_d = S_SUBA;
        end else begin
          state_d = S_SUBB;
        end
      end
      S_SUBA: begin
        sub_a   = 1'b1;
        state_d = S_CMP;
      end
      S_SUBB: begin
        sub_b   = 1'b1;
        state_d = S_CMP;
      end
      S_DONE: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      gcd_q <= '0;
    end else begin
      state <= state_d;
      gcd_q <= gcd_d;
    end
  end

  assign gcd       = gcd_q;
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_gcd_control_path.sv
// Randomized self-checking bench for gcd_control_path against an arithmetic
// reference (Euclid by modulo, latency from quotient sums).
module tb_gcd_control_path;

  localparam int W = 8;
  localparam int TIMEOUT = 1000;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         start;
  logic [W-1:0] gcd;
  logic         done;
  logic [2:0]   dbg_state;

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  gcd_control_path #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .start     (start),
    .gcd       (gcd),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: mathematical gcd.
  function automatic int ref_gcd(input int x, input int y);
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Reference: number of single subtractions before the operands become
  // equal (or one is zero), computed in bulk from integer quotients.
  function automatic int ref_subs(input int x, input int y);
    int cnt, q;
    cnt = 0;
    while (x != 0 && y != 0 && x != y) begin
      if (x > y) begin
        q = (x - 1) / y;
        x = x - q * y;
      end else begin
        q = (y - 1) / x;
        y = y - q * x;
      end
      cnt += q;
    end
    return cnt;
  endfunction

  // driver: one full run with start held through done, then released
  task automatic run_gcd(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit scramble);
    int lat, exp_lat;
    logic [W-1:0] exp_g;
    @(negedge clk);
    check("idle_before_run", dbg_state, 0);
    a = ta;
    b = tb_v;
    start = 1'b1;
    exp_q.push_back(W'(ref_gcd(ta, tb_v)));
    exp_lat = 2 + 2 * ref_subs(ta, tb_v) + 1;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2 && scramble) begin
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
      end
      if (done || lat > TIMEOUT) break;
    end
    exp_g = exp_q.pop_front();
    if (lat > TIMEOUT) begin
      check("timeout", lat, exp_lat);
    end else begin
      check("latency", lat, exp_lat);
      check("gcd", gcd, exp_g);
      check("state_done", dbg_state, 5);
      @(posedge clk);
      #1;
      check("done_held", done, 1);
      check("gcd_held_in_done", gcd, exp_g);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("done_low_after", done, 0);
      check("state_idle_after", dbg_state, 0);
      check("gcd_kept", gcd, exp_g);
    end
    start = 1'b0;
  endtask

  typedef struct { logic [W-1:0] x; logic [W-1:0] y; } pair_t;
  pair_t directed[7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    a = '0;
    b = '0;
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gcd", gcd, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    directed[0] = '{8'd24, 8'd16};
    directed[1] = '{8'd17, 8'd5};
    directed[2] = '{8'd0, 8'd9};
    directed[3] = '{8'd0, 8'd0};
    directed[4] = '{8'd12, 8'd12};
    directed[5] = '{8'd255, 8'd1};
    directed[6] = '{8'd9, 8'd0};
    foreach (directed[i]) run_gcd(directed[i].x, directed[i].y, 1'b0);

    // async reset in the middle of a run
    @(negedge clk);
    a = 8'd24;
    b = 8'd16;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_suba", dbg_state, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", dbg_state, 0);
    check("async_rst_gcd", gcd, 0);
    check("async_rst_done", done, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_gcd(8'd24, 8'd16, 1'b0);

    // operands changed after capture must not matter
    run_gcd(8'd100, 8'd75, 1'b1);
    for (int i = 0; i < 25; i++) begin
      run_gcd(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
